cla_pg_pipe: RTL



---
 rtl/cla_pg_pipe_pkg.sv | 35 +++
 rtl/cla_grp4.sv | 28 ++
 rtl/cla_pg_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cla_pg_pipe_pkg.sv
// Shared types and the 4-bit carry-lookahead group function for cla_pg_pipe.
package cla_pg_pipe_pkg;

  localparam int unsigned GROUP_W = 4;
  // Widest supported operand; the stage-1 payload is sized to it and trimmed at use.
  localparam int unsigned MAX_W   = 64;

  typedef struct packed {
    logic [GROUP_W-1:0] c;     // carry into each bit of the group
    logic               gout;  // group generate
    logic               pout;  // group propagate
  } grp4_res_t;

  typedef struct packed {
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] p;
    logic             cin;
    logic             msb_a;
    logic             msb_b;
  } s1_pay_t;

  function automatic grp4_res_t grp4_la(input logic [GROUP_W-1:0] g,
                                        input logic [GROUP_W-1:0] p,
                                        input logic               cin);
    grp4_res_t r;
    r.c[0] = cin;
    r.c[1] = g[0] | (p[0] & cin);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    r.gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.pout = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_grp4.sv
// Combinational 4-bit lookahead group: per-bit carries from g/p/cin, plus group G/P.
module cla_grp4
  import cla_pg_pipe_pkg::*;
(
  input  logic [GROUP_W-1:0] g_i,
  input  logic [GROUP_W-1:0] p_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] c_o,
  output logic               gout_o,
  output logic               pout_o
);

  grp4_res_t res_c;
  grp4_res_t res_gp;
  logic      unused_res;

  // G/P are taken from a call with no carry-in so they carry no false dependency
  // on the inter-group lookahead that consumes them.
  assign res_c  = grp4_la(g_i, p_i, cin_i);
  assign res_gp = grp4_la(g_i, p_i, 1'b0);

  assign c_o    = res_c.c;
  assign gout_o = res_gp.gout;
  assign pout_o = res_gp.pout;

  assign unused_res = ^{res_c.gout, res_c.pout, res_gp.c};

endmodule

// File: rtl/cla_pg_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Define ADD_PIPE_OVF_EN to add the registered signed-overflow output out_ovf.
module cla_pg_pipe
  import cla_pg_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NGRP = int'(WIDTH / GROUP_W);

  logic             s1_v_q, s1_v_d;
  s1_pay_t          s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef ADD_PIPE_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s2_adv, s1_load, in_ready_c;
  logic [NGRP-1:0]  grp_g, grp_p;
  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] bit_c, sum_c;
  logic             la_acc, la_term;
  logic             unused_s1;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla_grp4 u_grp (
      .g_i    (s1_q.g[GROUP_W*k +: GROUP_W]),
      .p_i    (s1_q.p[GROUP_W*k +: GROUP_W]),
      .cin_i  (grp_c[k]),
      .c_o    (bit_c[GROUP_W*k +: GROUP_W]),
      .gout_o (grp_g[k]),
      .pout_o (grp_p[k])
    );
  end

  // Each group carry is a flat sum of products over all lower groups, not a chain.
  always_comb begin
    grp_c    = '0;
    la_acc   = 1'b0;
    la_term  = 1'b0;
    grp_c[0] = s1_q.cin;
    for (int k = 0; k < NGRP; k++) begin
      la_acc = s1_q.cin;
      for (int m = 0; m <= k; m++) la_acc = la_acc & grp_p[m];
      for (int j = 0; j <= k; j++) begin
        la_term = grp_g[j];
        for (int m = j + 1; m <= k; m++) la_term = la_term & grp_p[m];
        la_acc = la_acc | la_term;
      end
      grp_c[k+1] = la_acc;
    end
  end

  assign sum_c = s1_q.p[WIDTH-1:0] ^ bit_c;

  always_comb begin
    s2_adv     = s1_v_q & (~out_valid_q | out_ready);
    in_ready_c = ~s1_v_q | s2_adv;
    s1_load    = in_valid & in_ready_c;

    s1_v_d = s1_v_q;
    if (s1_load)     s1_v_d = 1'b1;
    else if (s2_adv) s1_v_d = 1'b0;

    s1_d = s1_q;
    if (s1_load) begin
      s1_d     = '0;
      s1_d.g   = MAX_W'(in_a & in_b);
      s1_d.p   = MAX_W'(in_a ^ in_b);
      s1_d.cin = in_cin;
`ifdef ADD_PIPE_OVF_EN
      s1_d.msb_a = in_a[WIDTH-1];
      s1_d.msb_b = in_b[WIDTH-1];
`endif
    end

    out_valid_d = out_valid_q;
    if (s2_adv)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    sum_d  = sum_q;
    cout_d = cout_q;
`ifdef ADD_PIPE_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (s2_adv) begin
      sum_d  = sum_c;
      cout_d = grp_c[NGRP];
`ifdef ADD_PIPE_OVF_EN
      ovf_d  = (s1_q.msb_a == s1_q.msb_b) & (sum_c[WIDTH-1] != s1_q.msb_a);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef ADD_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_v_q      <= s1_v_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef ADD_PIPE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef ADD_PIPE_OVF_EN
  assign out_ovf   = ovf_q;
  assign unused_s1 = ^{s1_q.g >> WIDTH, s1_q.p >> WIDTH};
`else
  assign unused_s1 = ^{s1_q.g >> WIDTH, s1_q.p >> WIDTH, s1_q.msb_a, s1_q.msb_b};
`endif

endmodule
